// File: rtl/mmul_pkg.sv
// -----------------------------------------------------------------------------
// mmul_pkg
// Shared definitions for the bit-serial modular multiplier accumulator.
//   state_t  : controller states (IDLE, RUN, OUT)
//   OPW      : operand width in bits
//   WORD_W   : width of one load/result word
//   WORDS    : number of words per operand
//   PW       : width of the accumulator and its intermediates (OPW + 2)
// -----------------------------------------------------------------------------
package mmul_pkg;

    localparam int OPW    = 256;
    localparam int WORD_W = 16;
    localparam int WORDS  = 16;
    localparam int PW     = OPW + 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        OUT  = 2'd2
    } state_t;

endpackage : mmul_pkg

// File: rtl/mmul_cond_sub.sv
// -----------------------------------------------------------------------------
// mmul_cond_sub
// Combinational conditional subtract: o_y = (i_x >= i_n) ? i_x - i_n : i_x.
// Both operands are unsigned. The compare comes from the borrow of a single
// W+1 bit subtraction, so one subtractor serves both the test and the result.
// Ports:
//   i_x  in  W  value to be reduced
//   i_n  in  W  modulus
//   o_y  out W  reduced value
// -----------------------------------------------------------------------------
module mmul_cond_sub #(
    parameter int W = 258
) (
    input  logic [W-1:0] i_x,
    input  logic [W-1:0] i_n,
    output logic [W-1:0] o_y
);

    logic [W:0] w_diff;

    // w_diff[W] is the borrow: set exactly when i_x < i_n.
    assign w_diff = {1'b0, i_x} - {1'b0, i_n};
    assign o_y    = w_diff[W] ? i_x : w_diff[W-1:0];

endmodule : mmul_cond_sub

// File: rtl/mmul_acc_p.sv
// -----------------------------------------------------------------------------
// mmul_acc_p
// Bit-serial interleaved modular multiplier accumulator: P = A * B mod N,
// 256-bit operands. B arrives MSB first from an external shift register
// (b256), which this block advances with sel_ls while in RUN. A and N are
// loaded as 16-bit words in IDLE; the result is streamed out as 16 words,
// least significant first, over a valid/ready handshake.
//
// Handshake: out_valid is high for the whole OUT state; a word transfers on a
// rising edge where out_valid & out_ready are both high. While out_valid is
// high and out_ready low, out_data is held stable. One word per cycle when
// out_ready stays high.
//
// Optional build macro: MMUL_ACC_RANGE_CHECK_EN
//   defined   : start is refused (err=1, stay in IDLE) when A >= N or N == 0;
//               err clears on the next accepted start.
//   undefined : no check, err is tied low.
//
// Ports:
//   clk        in   1   clock
//   rst_n      in   1   asynchronous active-low reset
//   wr_en      in   1   operand word write strobe (IDLE only)
//   wr_sel     in   1   0 = A, 1 = N
//   wr_addr    in   4   word index, 0 = least significant
//   wr_data    in   16  operand word
//   start      in   1   begin multiplication (sampled in IDLE only)
//   b256       in   1   current MSB of the B register
//   sel_ls     out  1   shift-left command to the B register (RUN)
//   busy       out  1   high in RUN and OUT
//   out_data   out  16  result word, 0 outside OUT
//   out_valid  out  1   out_data valid (OUT)
//   out_ready  in   1   consumer ready
//   err        out  1   range-check flag
//   o_state    out  2   current controller state, for observation
// -----------------------------------------------------------------------------
module mmul_acc_p
    import mmul_pkg::*;
#(
    parameter int WORDS = 16,
    parameter int CNT_W = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_en,
    input  logic        wr_sel,
    input  logic [3:0]  wr_addr,
    input  logic [15:0] wr_data,
    input  logic        start,
    input  logic        b256,
    output logic        sel_ls,
    output logic        busy,
    output logic [15:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        err,
    output state_t      o_state
);

    localparam int OW  = WORD_W * WORDS;
    localparam int AW  = OW + 2;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t           r_state;
    state_t           w_next_state;
    logic [OW-1:0]    r_a;
    logic [OW-1:0]    r_n;
    logic [AW-1:0]    r_p;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_wcnt;

    logic             w_range_bad;
    logic             w_start_go;
    logic             w_last_bit;
    logic             w_last_word;
    logic [AW-1:0]    w_add;
    logic [AW-1:0]    w_n_ext;
    logic [AW-1:0]    w_red1;
    logic [AW-1:0]    w_red2;
    logic [OW-1:0]    w_res;
    logic [7:0]       w_wr_base;
    logic [7:0]       w_rd_base;

    // ------------------------------------------------------------------
    // Range check on start
    // ------------------------------------------------------------------
`ifdef MMUL_ACC_RANGE_CHECK_EN
    logic r_err;

    assign w_range_bad = (r_a >= r_n) || (r_n == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (r_state == IDLE && start) begin
            // Every start sampled in IDLE re-evaluates the flag, so an
            // accepted start clears it and a refused one sets it.
            r_err <= w_range_bad;
        end
    end

    assign err = r_err;
`else
    assign w_range_bad = 1'b0;
    assign err         = 1'b0;
`endif

    assign w_start_go  = start && !w_range_bad;
    assign w_last_bit  = (r_cnt == {CNT_W{1'b1}});
    assign w_last_word = (r_wcnt == 4'hF);

    // ------------------------------------------------------------------
    // Datapath step: t = 2P + (b ? A : 0), then up to two subtractions of N.
    // With A < N and P < N the sum is below 3N, so two conditional
    // subtractions always bring it back under N.
    // ------------------------------------------------------------------
    assign w_n_ext = {2'b00, r_n};
    assign w_add   = (r_p << 1) + (b256 ? {2'b00, r_a} : '0);

    mmul_cond_sub #(.W(AW)) u_red1 (
        .i_x (w_add),
        .i_n (w_n_ext),
        .o_y (w_red1)
    );

    mmul_cond_sub #(.W(AW)) u_red2 (
        .i_x (w_red1),
        .i_n (w_n_ext),
        .o_y (w_red2)
    );

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        sel_ls       = 1'b0;
        busy         = 1'b0;
        out_valid    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_start_go) begin
                    w_next_state = RUN;
                end
            end
            RUN: begin
                sel_ls = 1'b1;
                busy   = 1'b1;
                if (w_last_bit) begin
                    w_next_state = OUT;
                end
            end
            OUT: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready && w_last_word) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    assign o_state = r_state;

    // ------------------------------------------------------------------
    // Operand registers: written only while idle
    // ------------------------------------------------------------------
    assign w_wr_base = {wr_addr, 4'b0000};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a <= '0;
            r_n <= '0;
        end else if (r_state == IDLE && wr_en) begin
            if (wr_sel) begin
                r_n[w_wr_base +: WORD_W] <= wr_data;
            end else begin
                r_a[w_wr_base +: WORD_W] <= wr_data;
            end
        end
    end

    // ------------------------------------------------------------------
    // Accumulator and counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_p    <= '0;
            r_cnt  <= '0;
            r_wcnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_start_go) begin
                        r_p   <= '0;
                        r_cnt <= '0;
                    end
                end
                RUN: begin
                    r_p   <= w_red2;
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last_bit) begin
                        r_wcnt <= '0;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        r_wcnt <= r_wcnt + 1'b1;
                    end
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Result word select. P < N < 2^256 once a run completes, so the low
    // 256 bits carry the whole result.
    // ------------------------------------------------------------------
    assign w_res     = r_p[OW-1:0];
    assign w_rd_base = {r_wcnt, 4'b0000};
    assign out_data  = (r_state == OUT) ? w_res[w_rd_base +: WORD_W] : '0;

endmodule : mmul_acc_p

// File: doc/mmul_acc_p.md
# mmul_acc_p

Bit-serial interleaved modular multiplier accumulator computing P = A·B mod N for 256-bit operands. It sits directly downstream of the 256-bit B operand shift register. It consumes that register's MSB output (b256) one bit per cycle while driving its shift-left control. A and N are loaded as 16-bit words. The 256-bit result is streamed out as 16 words through a valid/ready handshake to the result register file.

## Interface
Parameters:
- WORDS, 16, number of 16-bit words per operand (operand width = 16·WORDS = 256)
- CNT_W, 8, width of bit counter (log2 of 16·WORDS)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- wr_en  in  1  operand word write strobe
- wr_sel  in  1  0 = write A, 1 = write N
- wr_addr  in  4  word index, 0 = least significant
- wr_data  in  16  operand word
- start  in  1  begin multiplication (pulse, sampled in IDLE only)
- b256  in  1  current MSB of B register
- sel_ls  out  1  shift-left command to B register (1 during RUN)
- busy  out  1  high in RUN and OUT
- out_data  out  16  result word, least significant first
- out_valid  out  1  out_data valid
- out_ready  in  1  consumer accepts word when out_valid & out_ready
- err  out  1  range-check flag (only with MMUL_ACC_RANGE_CHECK_EN)

## Operation
- Registers: A[255:0], N[255:0], P[257:0], bit counter cnt, word counter wcnt[3:0].
- FSM states: IDLE, RUN, OUT.
- IDLE:
  - wr_en writes wr_data into A or N word wr_addr.
  - Writes are ignored outside IDLE.
  - start → RUN, with P=0 and cnt=0.
- RUN, one step per cycle:
  - t = 2P + (b256 ? A : 0)
  - if t ≥ N then t −= N; if t ≥ N again then t −= N
  - P ← t
- sel_ls=1 for every RUN cycle, so the B register advances one bit per step. The block samples b256 combinationally in the same cycle.
- Arithmetic: intermediates are 258 bits and are unsigned throughout. The result is valid only if A < N and N is nonzero. Odd N is not required.
- After the step with cnt=255: → OUT, with wcnt=0.
- OUT: out_data = P[16·wcnt+15 : 16·wcnt] and out_valid=1.
  - On a handshake, wcnt increments.
  - A handshake at wcnt=15 → IDLE.
  - A and N are retained, so a new start without reloading reuses them.
- start in RUN or OUT is ignored. wr_en together with start in IDLE: the write takes effect and RUN uses the written value on the next cycle.

## Timing
- Reset values: sel_ls=0, busy=0, out_valid=0, out_data=0, err=0, state=IDLE. A, N and P are cleared to 0.
- Reset asserted mid-RUN or mid-OUT: the block returns to IDLE immediately. Partial results are discarded, and the B register stops shifting because sel_ls drops asynchronously.
- Latency: start sampled at edge k; RUN occupies edges k+1..k+256; out_valid first high after edge k+256. The result occupies at least 16 cycles of OUT.
- out_valid holds, with out_data stable, until out_ready. Back-to-back words are accepted one per cycle.
- busy rises the cycle after start is sampled and falls the cycle after the final handshake.

## Configuration
- MMUL_ACC_RANGE_CHECK_EN defined: on start, the block compares A ≥ N and N == 0.
  - If either holds, err=1, the FSM stays in IDLE, and sel_ls stays 0.
  - err clears on the next accepted start or on reset.
- Undefined: no check; err is tied to 0. An out-of-range A produces an unspecified result, but the FSM still completes normally.

## Structure
- Shared package mmul_pkg:
  - state enum {IDLE, RUN, OUT}
  - constants OPW=256, WORD_W=16, WORDS=16
- Sub-module mmul_cond_sub: a 258-bit combinational "if x ≥ N then x−N". It is instantiated twice in series for the reduction.

## Test plan
- Load A=3, N=7, start, drive a B stream encoding B=5 → after 256 RUN cycles, words = {0x0001, 0x0000 ×15}.
- A=N−1, B=N−1, N=2^255+19 → result 1. Word 0 = 0x0001 and words 1..15 = 0.
- B=0 (b256 always 0) with any A, N → all 16 output words 0x0000. sel_ls is high for exactly 256 cycles.
- start pulsed again during RUN and during OUT with out_ready=0 → ignored. Output words hold stable until out_ready is raised, then complete one word per cycle.
- Reset asserted at RUN cycle 100 → sel_ls, busy and out_valid are 0 immediately. A subsequent reload and start yields a correct 3·5 mod 7 = 1.
- With MMUL_ACC_RANGE_CHECK_EN: A=9, N=7, start → err=1, busy stays 0, no sel_ls. Then reload A=2 and start → err=0, normal run.
